branch_resolution_unit: RTL

Decode-stage branch resolver: the other end of the dynamic branch predictor's interface. It evaluates the branch in IF/ID against the flags or the register operand, and compares the outcome with the prediction the fetch stage made. It drives the predictor's update inputs (`was_branch`, `actual_taken`, `actual_target`, `branch_mispredicted`) and the fetch redirect/flush. If the pipeline is frozen between resolution and commit, it holds the resolved outcome so exactly one update is issued per branch.

---
 rtl/branch_resolution_unit_pkg.sv | 32 +++
 rtl/branch_resolution_unit_if.sv | 50 +++++
 rtl/branch_resolution_unit_cond_eval.sv | 29 ++
 rtl/branch_resolution_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/branch_resolution_unit_pkg.sv
// Shared types and constants for the decode-stage branch resolver.
// Flag vectors are packed {Z,V,N}, so Z is the MSB.
package branch_pkg;

   typedef enum logic [2:0] {
      NEQ    = 3'd0,
      EQ     = 3'd1,
      GT     = 3'd2,
      LT     = 3'd3,
      GTE    = 3'd4,
      LTE    = 3'd5,
      OVFL   = 3'd6,
      UNCOND = 3'd7
   } cond_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_OPS = 2'd1,
      HELD     = 2'd2
   } br_state_e;

   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_N = 0;

   // imm9 counts words: sign-extend, then scale to bytes; wraps modulo 2^16.
   function automatic logic [15:0] b_target(input logic [15:0] pc_next,
                                            input logic [8:0]  imm9);
      return pc_next + {{6{imm9[8]}}, imm9, 1'b0};
   endfunction

endpackage

// File: rtl/branch_resolution_unit_if.sv
// IF/ID-side bundle between the decode pipeline and the branch resolver.
// The slave modport is the resolver; the master modport is the pipeline/predictor side.
interface branch_resolution_unit_if #(
   parameter int unsigned CNT_W = 32
);
   logic             valid;
   logic             is_branch;
   logic             is_br_reg;
   logic [2:0]       cond;
   logic [8:0]       imm9;
   logic [15:0]      rs_data;
   logic             rs_ready;
   logic [2:0]       flags;
   logic             flags_ready;
   logic [15:0]      PC_next;
   logic [1:0]       IF_ID_prediction;
   logic [15:0]      IF_ID_predicted_target;
   logic             enable;
   logic             kill;

   logic             was_branch;
   logic             actual_taken;
   logic             branch_mispredicted;
   logic [15:0]      actual_target;
   logic             redirect_valid;
   logic [15:0]      redirect_PC;
   logic             flush_IF_ID;
   logic             stall;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] mispredict_count;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output valid, is_branch, is_br_reg, cond, imm9, rs_data, rs_ready,
             flags, flags_ready, PC_next, IF_ID_prediction,
             IF_ID_predicted_target, enable, kill,
      input  was_branch, actual_taken, branch_mispredicted, actual_target,
             redirect_valid, redirect_PC, flush_IF_ID, stall,
             branch_count, mispredict_count, stall_count
   );

   modport slave (
      input  valid, is_branch, is_br_reg, cond, imm9, rs_data, rs_ready,
             flags, flags_ready, PC_next, IF_ID_prediction,
             IF_ID_predicted_target, enable, kill,
      output was_branch, actual_taken, branch_mispredicted, actual_target,
             redirect_valid, redirect_PC, flush_IF_ID, stall,
             branch_count, mispredict_count, stall_count
   );
endinterface

// File: rtl/branch_resolution_unit_cond_eval.sv
// Combinational branch condition evaluator: ccc code against {Z,V,N}.
module branch_cond_eval
   import branch_pkg::*;
(
   input  logic [2:0] cond_i,
   input  logic [2:0] flags_i,
   output logic       taken_o
);
   logic z, v, n;

   assign z = flags_i[FLAG_Z];
   assign v = flags_i[FLAG_V];
   assign n = flags_i[FLAG_N];

   always_comb begin
      taken_o = 1'b0;
      unique case (cond_e'(cond_i))
         NEQ:     taken_o = !z;
         EQ:      taken_o = z;
         GT:      taken_o = !z && !n;
         LT:      taken_o = n;
         GTE:     taken_o = z || !n;
         LTE:     taken_o = n || z;
         OVFL:    taken_o = v;
         UNCOND:  taken_o = 1'b1;
         default: taken_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/branch_resolution_unit.sv
// Decode-stage branch resolver: evaluates the IF/ID branch, drives predictor update and
// fetch redirect in the advancing cycle, and holds the outcome while the pipeline is frozen.
module branch_resolution_unit
   import branch_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   branch_resolution_unit_if.slave  bus
);
   logic             taken_live;
   logic [15:0]      target_live;
   logic [15:0]      redir_live;
   logic             misp_live;
   logic             ops_ready;
   logic             br_live;

   br_state_e        state_q, state_d;
   logic             held_taken_q;
   logic [15:0]      held_target_q;
   logic [15:0]      held_redir_q;
   logic             held_misp_q;
   logic [CNT_W-1:0] branch_cnt_q, misp_cnt_q, stall_cnt_q;

   logic             commit, stall_c, capture;
   logic             res_taken, res_misp;
   logic [15:0]      res_target, res_redir;

   branch_cond_eval u_cond_eval (
      .cond_i  (bus.cond),
      .flags_i (bus.flags),
      .taken_o (taken_live)
   );

   assign target_live = bus.is_br_reg ? bus.rs_data : b_target(bus.PC_next, bus.imm9);
   assign redir_live  = taken_live ? target_live : bus.PC_next;
   assign misp_live   = bus.is_branch &&
                        ((bus.IF_ID_prediction[1] != taken_live) ||
                         (bus.IF_ID_prediction[1] && taken_live &&
                          (bus.IF_ID_predicted_target != target_live)));
   // UNCOND never looks at the flags, so an outstanding flag writer cannot block it.
   assign ops_ready   = ((cond_e'(bus.cond) == UNCOND) || bus.flags_ready) &&
                        (!bus.is_br_reg || bus.rs_ready);
   assign br_live     = bus.valid && bus.is_branch && !bus.kill;

   always_comb begin
      state_d    = state_q;
      commit     = 1'b0;
      stall_c    = 1'b0;
      capture    = 1'b0;
      res_taken  = taken_live;
      res_target = target_live;
      res_misp   = misp_live;
      res_redir  = redir_live;
      unique case (state_q)
         IDLE, WAIT_OPS: begin
            if (!br_live) begin
               state_d = IDLE;
            end else if (!ops_ready) begin
               stall_c = 1'b1;
               state_d = WAIT_OPS;
            end else if (bus.enable) begin
               commit  = 1'b1;
               state_d = IDLE;
            end else begin
               capture = 1'b1;
               state_d = HELD;
            end
         end
         HELD: begin
            res_taken  = held_taken_q;
            res_target = held_target_q;
            res_misp   = held_misp_q;
            res_redir  = held_redir_q;
            if (bus.kill) begin
               state_d = IDLE;
            end else if (bus.enable) begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Outputs are combinational from live inputs, so reset must mask them explicitly.
      if (!rst_n) begin
         commit  = 1'b0;
         stall_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         held_taken_q  <= 1'b0;
         held_target_q <= '0;
         held_redir_q  <= '0;
         held_misp_q   <= 1'b0;
         branch_cnt_q  <= '0;
         misp_cnt_q    <= '0;
         stall_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            held_taken_q  <= taken_live;
            held_target_q <= target_live;
            held_redir_q  <= redir_live;
            held_misp_q   <= misp_live;
         end
         if (commit) begin
            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
         end
         if (commit && res_misp) begin
            misp_cnt_q <= misp_cnt_q + CNT_W'(1);
         end
         if (stall_c) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.was_branch          = commit;
   assign bus.actual_taken        = commit && res_taken;
   assign bus.actual_target       = (commit && res_taken) ? res_target : '0;
   assign bus.branch_mispredicted = commit && res_misp;
   assign bus.redirect_valid      = commit && res_misp;
   assign bus.flush_IF_ID         = commit && res_misp;
   assign bus.redirect_PC         = (commit && res_misp) ? res_redir : '0;
   assign bus.stall               = stall_c;
   assign bus.branch_count        = branch_cnt_q;
   assign bus.mispredict_count    = misp_cnt_q;
   assign bus.stall_count         = stall_cnt_q;

endmodule
